// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART control blocks.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  localparam logic [2:0] BAUD_1200   = 3'b000;
  localparam logic [2:0] BAUD_2400   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = cnt_width(N - 1)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        winner[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; owns tx enable and baud select
// so neither changes while a frame is in flight.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [2:0]         baud_cfg,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               timeout_err,
  output logic [7:0]         tx_data,
  output logic               tx_wr,
  output logic               tx_en,
  output logic [2:0]         baud_select,
  input  logic               tx_busy
);

  localparam int unsigned IW       = cnt_width(N_REQ - 1);
  localparam int unsigned CNT_MAX  = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CW       = cnt_width(CNT_MAX);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] win_q, win_d;

  logic [N_REQ-1:0] grant_d, done_d;
  logic             timeout_d, tx_wr_d, tx_en_d;
  logic [7:0]       tx_data_d;
  logic [2:0]       baud_d;

  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;
  logic [7:0]       req_bytes [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_oh),
    .idx    (arb_idx)
  );

  // Next-state and next-output decode; pulses default low, config holds.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    grant_d   = '0;
    done_d    = '0;
    timeout_d = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data;
    tx_en_d   = tx_en;
    baud_d    = baud_select;

    unique case (state_q)
      ST_IDLE: begin
        baud_d  = baud_cfg;
        tx_en_d = enable;
        if (enable && (|req)) begin
          grant_d   = arb_oh;
          win_d     = arb_oh;
          tx_wr_d   = 1'b1;
          tx_data_d = req_bytes[arb_idx];
          tx_en_d   = 1'b1;
          ptr_d     = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
          cnt_d     = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = win_q;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if ((GAP_CYCLES == 0) || (cnt_q == CW'(GAP_LAST))) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      tx_wr       <= 1'b0;
      tx_data     <= '0;
      tx_en       <= 1'b0;
      baud_select <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      grant       <= grant_d;
      done        <= done_d;
      timeout_err <= timeout_d;
      tx_wr       <= tx_wr_d;
      tx_data     <= tx_data_d;
      tx_en       <= tx_en_d;
      baud_select <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grant/done/timeout events are
// queued by the stimulus and popped by an independent monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned T     = 16;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned FRAME = 12;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_TO    = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] vec;
    logic [7:0]   data;
    logic [2:0]   baud;
    int           gap;
  } exp_t;

  logic           clk, reset, enable, tx_busy;
  logic [N-1:0]   req, grant, done;
  logic [8*N-1:0] req_data;
  logic [2:0]     baud_cfg, baud_select;
  logic           timeout_err, tx_wr, tx_en;
  logic [7:0]     tx_data;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_ev_cyc = 0;
  int         rst_epoch = 0;
  bit         tx_live = 1'b1;
  exp_t       exp_q[$];
  logic [7:0] rx_q[$];

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(T), .GAP_CYCLES(GAPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .req_data    (req_data),
    .baud_cfg    (baud_cfg),
    .grant       (grant),
    .done        (done),
    .timeout_err (timeout_err),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_en       (tx_en),
    .baud_select (baud_select),
    .tx_busy     (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge reset) rst_epoch = rst_epoch + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input logic [N-1:0] vec, input logic [7:0] data,
                      input logic [2:0] baud, input int gap);
    exp_t e;
    e.kind = kind; e.vec = vec; e.data = data; e.baud = baud; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [N-1:0] vec);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d vec=%b expected none", kind, vec);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.vec !== vec) begin
        failures++;
        $display("FAIL event: got kind=%0d vec=%b expected kind=%0d vec=%b", kind, vec, e.kind, e.vec);
      end else begin
        if (kind == EV_GRANT) check("grant_data", 32'(tx_data), 32'(e.data));
        check("event_baud", 32'(baud_select), 32'(e.baud));
        if (e.gap >= 0) check("event_gap", 32'(cyc - last_ev_cyc), 32'(e.gap));
      end
    end
    last_ev_cyc = cyc;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if ((|grant) || tx_wr) check("wr_with_grant", 32'(tx_wr), 32'(|grant));
      if (|grant) observe(EV_GRANT, grant);
      if (|done) observe(EV_DONE, done);
      if (timeout_err) observe(EV_TO, '0);
    end
  end

  // Requesters drop their line in the cycle they see their grant.
  always @(negedge clk) req = req & ~grant;

  // Transmitter model: busy for FRAME cycles after each accepted strobe.
  initial begin
    logic [7:0] cap;
    int         ep;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset && tx_wr && tx_live) begin
        cap = tx_data;
        ep  = rst_epoch;
        rx_q.push_back(cap);
        tx_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        if (ep == rst_epoch) check("tx_data_stable", 32'(tx_data), 32'(cap));
        tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (grant == '0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("grant_seen", 32'(|grant), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    check({tag, "_tx_wr"}, 32'(tx_wr), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    check({tag, "_baud"}, 32'(baud_select), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_bytes [4];
    reset = 1'b0; enable = 1'b0; req = '0; req_data = '0; baud_cfg = 3'b111;
    cycles(3);
    check_all_zero("reset");
    reset = 1'b1;

    // Single request from requester 0.
    enable = 1'b1;
    cycles(2);
    check("baud_follows_cfg", 32'(baud_select), 32'h7);
    req_data[7:0] = 8'hFA;
    push(EV_GRANT, 4'b0001, 8'hFA, 3'b111, -1);
    push(EV_DONE, 4'b0001, 8'h00, 3'b111, FRAME + 1);
    req[0] = 1'b1;
    wait_empty(60);
    check("rx_count_single", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("rx_byte_single", 32'(rx_q[0]), 32'hFA);
    rx_q.delete();

    // All four at once from a fresh pointer.
    do_reset();
    req_data = 32'hFFC407FA;
    exp_bytes[0] = 8'hFA; exp_bytes[1] = 8'h07; exp_bytes[2] = 8'hC4; exp_bytes[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      push(EV_GRANT, 4'(1 << i), exp_bytes[i], 3'b111, (i == 0) ? -1 : int'(GAPC + 1));
      push(EV_DONE, 4'(1 << i), 8'h00, 3'b111, FRAME + 1);
    end
    req = 4'b1111;
    wait_empty(200);
    check("rx_count_rotate", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check("rx_byte_rotate", 32'(rx_q[i]), 32'(exp_bytes[i]));
    rx_q.delete();

    // Pointer wrap: serve 2, then 0101 gives 0 before 2.
    push(EV_GRANT, 4'b0100, 8'hC4, 3'b111, -1);
    push(EV_DONE, 4'b0100, 8'h00, 3'b111, FRAME + 1);
    req[2] = 1'b1;
    wait_empty(60);
    push(EV_GRANT, 4'b0001, 8'hFA, 3'b111, -1);
    push(EV_DONE, 4'b0001, 8'h00, 3'b111, FRAME + 1);
    push(EV_GRANT, 4'b0100, 8'hC4, 3'b111, GAPC + 1);
    push(EV_DONE, 4'b0100, 8'h00, 3'b111, FRAME + 1);
    req = req | 4'b0101;
    wait_empty(100);

    // Transmitter never goes busy: timeout, then the FSM recovers.
    tx_live = 1'b0;
    req_data[15:8] = 8'h11;
    push(EV_GRANT, 4'b0010, 8'h11, 3'b111, -1);
    push(EV_TO, 4'b0000, 8'h00, 3'b111, T + 1);
    req[1] = 1'b1;
    wait_grant(20);
    tx_live = 1'b1;
    req_data[31:24] = 8'h99;
    push(EV_GRANT, 4'b1000, 8'h99, 3'b111, GAPC + 1);
    push(EV_DONE, 4'b1000, 8'h00, 3'b111, FRAME + 1);
    req[3] = 1'b1;
    wait_empty(100);

    // Enable gating in IDLE; disabling mid-frame still completes the frame.
    enable = 1'b0;
    req_data[15:8] = 8'h42;
    req[1] = 1'b1;
    cycles(6);
    check("held_off_grant", 32'(grant), 32'd0);
    check("tx_en_idle_off", 32'(tx_en), 32'd0);
    push(EV_GRANT, 4'b0010, 8'h42, 3'b111, -1);
    push(EV_DONE, 4'b0010, 8'h00, 3'b111, FRAME + 1);
    enable = 1'b1;
    cycles(1);
    check("grant_after_enable", 32'(grant), 32'h2);
    enable = 1'b0;
    req_data[23:16] = 8'h77;
    req[2] = 1'b1;
    wait_empty(60);
    check("tx_en_in_gap", 32'(tx_en), 32'd1);
    cycles(8);
    check("no_grant_disabled", 32'(grant), 32'd0);
    check("tx_en_dropped", 32'(tx_en), 32'd0);

    // baud_cfg change mid-frame is deferred to IDLE.
    push(EV_GRANT, 4'b0100, 8'h77, 3'b111, -1);
    push(EV_DONE, 4'b0100, 8'h00, 3'b111, FRAME + 1);
    enable = 1'b1;
    wait_grant(10);
    cycles(4);
    baud_cfg = 3'b011;
    cycles(2);
    check("baud_frozen", 32'(baud_select), 32'h7);
    wait_empty(60);
    cycles(5);
    check("baud_updated", 32'(baud_select), 32'h3);

    // Reset mid-frame: outputs clear at once, no done, pointer back to 0.
    req_data[7:0] = 8'h5A;
    push(EV_GRANT, 4'b0001, 8'h5A, 3'b011, -1);
    req[0] = 1'b1;
    wait_grant(20);
    cycles(3);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    cycles(2);
    reset = 1'b1;
    for (int n = 0; n < 40 && tx_busy; n++) cycles(1);
    check("tx_idle_after_abort", 32'(tx_busy), 32'd0);
    req_data[7:0] = 8'h33;
    req_data[31:24] = 8'hCC;
    push(EV_GRANT, 4'b0001, 8'h33, 3'b011, -1);
    push(EV_DONE, 4'b0001, 8'h00, 3'b011, FRAME + 1);
    push(EV_GRANT, 4'b1000, 8'hCC, 3'b011, GAPC + 1);
    push(EV_DONE, 4'b1000, 8'h00, 3'b011, FRAME + 1);
    req = 4'b1001;
    wait_empty(100);

    cycles(4);
    check("leftover_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
